// File: rtl/led_seq_ctrl.sv
// rtl/led_seq_ctrl.sv - PLL-lock gated LED pattern sequencer with a valid/ready mode request port.
// Waits for lock, settles, then steps an 8-slot pattern once per prescaler wrap.
module led_seq_ctrl #(
  parameter int PRESCALE_W = 22,
  parameter int SETTLE_CYC = 1000
) (
  input  logic       clk0,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic [1:0] mode,
  input  logic       mode_valid,
  output logic       mode_ready,
  output logic       led,
  output logic       running,
  output logic       lock_lost
);

  localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {WAIT_LOCK, SETTLE, RUN} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CNT_W-1:0]        r_settle_cnt;
  logic [PRESCALE_W-1:0]   r_prescale;
  logic [2:0]              r_step;
  logic [1:0]              r_mode_act;
  logic [1:0]              r_mode_pend;
  logic                    r_pend_valid;
  logic                    r_led;
  logic                    r_lock_lost;

  logic                    w_settle_clr;
  logic                    w_settle_inc;
  logic                    w_enter_run;
  logic                    w_stay_run;
  logic                    w_tick;
  logic                    w_accept;
  logic [2:0]              w_step_inc;

  function automatic logic led_for(input logic [1:0] m, input logic [2:0] s);
    case (m)
      2'd0:    led_for = 1'b0;
      2'd1:    led_for = 1'b1;
      2'd2:    led_for = s[0];
      default: led_for = (s == 3'd0) || (s == 3'd2);
    endcase
  endfunction

  always_ff @(posedge clk0) begin
    if (!rst) begin
      r_state <= WAIT_LOCK;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_settle_clr = 1'b0;
    w_settle_inc = 1'b0;
    w_enter_run  = 1'b0;
    w_stay_run   = 1'b0;
    case (r_state)
      WAIT_LOCK: begin
        if (pll_locked) begin
          w_state_nxt  = SETTLE;
          w_settle_clr = 1'b1;
        end
      end
      SETTLE: begin
        if (!pll_locked) begin
          w_state_nxt  = WAIT_LOCK;
          w_settle_clr = 1'b1;
        end else if (r_settle_cnt == SETTLE_LAST) begin
          w_state_nxt = RUN;
          w_enter_run = 1'b1;
        end else begin
          w_settle_inc = 1'b1;
        end
      end
      RUN: begin
        if (!pll_locked) begin
          w_state_nxt = WAIT_LOCK;
        end else begin
          w_stay_run = 1'b1;
        end
      end
      default: w_state_nxt = WAIT_LOCK;
    endcase
  end

  // A tick on the edge that loses lock is dropped so a pending mode survives to WAIT_LOCK.
  assign w_tick     = w_stay_run && (&r_prescale);
  assign w_accept   = mode_valid && !r_pend_valid;
  assign w_step_inc = r_step + 3'd1;

  always_ff @(posedge clk0) begin
    if (!rst) begin
      r_settle_cnt <= '0;
      r_prescale   <= '0;
      r_step       <= 3'd0;
      r_mode_act   <= 2'd2;
      r_mode_pend  <= 2'd0;
      r_pend_valid <= 1'b0;
      r_led        <= 1'b0;
      r_lock_lost  <= 1'b0;
    end else begin
      if (w_settle_clr) begin
        r_settle_cnt <= '0;
      end else if (w_settle_inc) begin
        r_settle_cnt <= r_settle_cnt + CNT_W'(1);
      end

      if (w_enter_run) begin
        r_prescale <= '0;
        r_step     <= 3'd0;
      end else if (w_stay_run) begin
        r_prescale <= r_prescale + PRESCALE_W'(1);
      end

      if (!w_stay_run) begin
        r_led <= 1'b0;
      end else if (w_tick) begin
        if (r_pend_valid) begin
          r_mode_act   <= r_mode_pend;
          r_step       <= 3'd0;
          r_led        <= led_for(r_mode_pend, 3'd0);
          r_pend_valid <= 1'b0;
        end else begin
          r_step <= w_step_inc;
          r_led  <= led_for(r_mode_act, w_step_inc);
        end
      end

      if (w_accept) begin
        r_mode_pend  <= mode;
        r_pend_valid <= 1'b1;
      end else if (r_pend_valid && (r_state != RUN)) begin
        r_mode_act   <= r_mode_pend;
        r_pend_valid <= 1'b0;
      end

      if ((r_state == RUN) && !pll_locked) begin
        r_lock_lost <= 1'b1;
      end
    end
  end

  assign mode_ready = !r_pend_valid;
  assign led        = r_led;
  assign running    = (r_state == RUN);
  assign lock_lost  = r_lock_lost;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb/tb_led_seq_ctrl.sv - directed self-checking bench for led_seq_ctrl (PRESCALE_W=3, SETTLE_CYC=4).
module tb_led_seq_ctrl;

  logic       clk0;
  logic       rst;
  logic       pll_locked;
  logic [1:0] mode;
  logic       mode_valid;
  logic       mode_ready;
  logic       led;
  logic       running;
  logic       lock_lost;

  int n_checks = 0;
  int n_fail   = 0;
  logic hb [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  led_seq_ctrl #(.PRESCALE_W(3), .SETTLE_CYC(4)) dut (
    .clk0       (clk0),
    .rst        (rst),
    .pll_locked (pll_locked),
    .mode       (mode),
    .mode_valid (mode_valid),
    .mode_ready (mode_ready),
    .led        (led),
    .running    (running),
    .lock_lost  (lock_lost)
  );

  initial clk0 = 1'b0;
  always #5 clk0 = ~clk0;

  task automatic check(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step_n(input int n);
    repeat (n) begin
      @(posedge clk0);
      #1;
    end
  endtask

  initial begin
    rst        = 1'b0;
    pll_locked = 1'b1;
    mode       = 2'd0;
    mode_valid = 1'b0;

    // reset state
    step_n(2);
    check("rst_led", led, 1'b0);
    check("rst_running", running, 1'b0);
    check("rst_lock_lost", lock_lost, 1'b0);
    check("rst_ready", mode_ready, 1'b1);

    // lock held: RUN exactly 5 edges after release
    rst = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step_n(1);
      check("startup_running", running, k == 5);
      check("startup_led", led, 1'b0);
    end

    // default blink: toggle every 8 cycles, step wraps after 64
    for (int c = 1; c <= 72; c++) begin
      step_n(1);
      check("blink_led", led, 1'((c / 8) % 2));
    end

    // heartbeat request mid-period
    step_n(3);
    check("hb_ready_pre", mode_ready, 1'b1);
    mode       = 2'd3;
    mode_valid = 1'b1;
    step_n(1);
    mode_valid = 1'b0;
    check("hb_ready_acc", mode_ready, 1'b0);
    step_n(3);
    check("hb_ready_wait", mode_ready, 1'b0);
    check("hb_led_old", led, 1'b1);
    step_n(1);
    check("hb_led_apply", led, 1'b1);
    check("hb_ready_apply", mode_ready, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      step_n(8);
      check("hb_pattern", led, hb[k % 8]);
    end

    // request in tick cycle waits for the following tick
    step_n(7);
    mode       = 2'd1;
    mode_valid = 1'b1;
    step_n(1);
    mode_valid = 1'b0;
    check("tickreq_old_mode", led, 1'b0);
    check("tickreq_ready", mode_ready, 1'b0);
    step_n(7);
    check("tickreq_hold", led, 1'b0);
    step_n(1);
    check("tickreq_apply", led, 1'b1);
    check("tickreq_ready_back", mode_ready, 1'b1);
    step_n(8);
    check("solid_led", led, 1'b1);

    // lock loss with a pending mode-0 request
    mode       = 2'd0;
    mode_valid = 1'b1;
    step_n(1);
    mode_valid = 1'b0;
    pll_locked = 1'b0;
    step_n(1);
    check("loss_led", led, 1'b0);
    check("loss_running", running, 1'b0);
    check("loss_flag", lock_lost, 1'b1);
    check("loss_pend_kept", mode_ready, 1'b0);
    step_n(1);
    check("loss_pend_apply", mode_ready, 1'b1);
    pll_locked = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step_n(1);
      check("relock_running", running, k == 5);
      check("relock_flag", lock_lost, 1'b1);
    end
    step_n(8);
    check("off_led", led, 1'b0);
    check("off_flag", lock_lost, 1'b1);

    // reset clears lock_lost; lock glitch at settle count 2
    rst = 1'b0;
    step_n(1);
    check("rst2_flag", lock_lost, 1'b0);
    check("rst2_running", running, 1'b0);
    rst = 1'b1;
    step_n(3);
    check("glitch_pre", running, 1'b0);
    pll_locked = 1'b0;
    step_n(1);
    check("glitch_running", running, 1'b0);
    pll_locked = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step_n(1);
      check("glitch_relock", running, k == 5);
      check("glitch_flag", lock_lost, 1'b0);
    end

    // reset overrides a concurrent request and restores blink
    mode       = 2'd1;
    mode_valid = 1'b1;
    rst        = 1'b0;
    step_n(1);
    mode_valid = 1'b0;
    check("rst3_ready", mode_ready, 1'b1);
    check("rst3_running", running, 1'b0);
    check("rst3_led", led, 1'b0);
    rst = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step_n(1);
      check("rst3_startup", running, k == 5);
    end
    step_n(8);
    check("rst3_blink_on", led, 1'b1);
    step_n(8);
    check("rst3_blink_off", led, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
